inv_sub_bytes_seq: RTL and testbench

- Sequential AES InvSubBytes engine for the decryption datapath.
- Accepts a 128-bit state over a valid/ready handshake and applies the inverse S-box to all 16 bytes using LANES parallel byte lanes over 16/LANES cycles.
- Returns the result over a second valid/ready handshake.
- Each lane computes the inverse affine transform, then the GF(2^8) multiplicative inverse (polynomial 0x11B, 0 maps to 0). This is the reverse direction of the forward S-box byte path.

---
 rtl/inv_sub_bytes_seq.sv | 191 +++++++++++++++++++
 tb/tb_inv_sub_bytes_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes engine, LANES byte lanes per cycle.
// Optional macro INV_SUB_BYTES_FWD_EN adds a mode port for the forward S-box.
module inv_sub_bytes_seq #(
    parameter int LANES = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic         mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy,
    output logic [15:0]  blk_count
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
          LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    localparam int LW = LANES * 8;
    localparam logic [3:0] STEP = 4'(LANES);
    localparam logic [3:0] LAST = 4'(16 - LANES);
    localparam logic [127:0] MASK0 = ~({128{1'b1}} >> LW);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t        r_fsm;
    state_t        w_fsm_nxt;
    logic [127:0]  r_state;
    logic [3:0]    r_idx;
    logic          r_out_valid;
    logic [15:0]   r_blk_cnt;
    logic          r_mode;
    logic          w_accept;
    logic          w_last;
    logic          w_fire;
    logic [LW-1:0] w_lanes;
    logic [127:0]  w_lane_full;
    logic [127:0]  w_repl;
    logic [127:0]  w_mask;
    logic [127:0]  w_next;

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
        end
        return p;
    endfunction

    // x^254: six square-and-multiply steps give x^127, one square more.
    function automatic logic [7:0] gfinv(input logic [7:0] x);
        logic [7:0] y;
        y = x;
        for (int i = 0; i < 6; i++) begin
            y = gmul(gmul(y, y), x);
        end
        return gmul(y, y);
    endfunction

    function automatic logic [7:0] inv_aff(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^
               {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

`ifdef INV_SUB_BYTES_FWD_EN
    function automatic logic [7:0] fwd_aff(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
               {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction
`endif

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [3:0] w_bi;
        logic [7:0] w_x;
        logic [7:0] w_gin;
        logic [7:0] w_g;
        logic [7:0] w_y;
        assign w_bi = r_idx + 4'(l);
        assign w_x  = r_state[{~w_bi, 3'b111} -: 8];
`ifdef INV_SUB_BYTES_FWD_EN
        assign w_gin = r_mode ? w_x : inv_aff(w_x);
        assign w_g   = gfinv(w_gin);
        assign w_y   = r_mode ? fwd_aff(w_g) : w_g;
`else
        assign w_gin = inv_aff(w_x);
        assign w_g   = gfinv(w_gin);
        assign w_y   = w_g;
`endif
        assign w_lanes[LW-1-8*l -: 8] = w_y;
    end

    // Left-align the lane results so they can be shifted to the group.
    always_comb begin
        w_lane_full = '0;
        w_lane_full[127 -: LW] = w_lanes;
    end

    assign w_repl = w_lane_full >> {r_idx, 3'b000};
    assign w_mask = MASK0 >> {r_idx, 3'b000};
    assign w_next = (r_state & ~w_mask) | w_repl;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    // Next-state and handshake decode.
    always_comb begin
        w_fsm_nxt = r_fsm;
        in_ready  = 1'b0;
        busy      = 1'b0;
        w_accept  = 1'b0;
        w_last    = 1'b0;
        w_fire    = 1'b0;
        unique case (r_fsm)
            S_IDLE: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid) w_fsm_nxt = S_BUSY;
            end
            S_BUSY: begin
                busy   = 1'b1;
                w_last = (r_idx == LAST);
                if (w_last) w_fsm_nxt = S_DONE;
            end
            S_DONE: begin
                busy   = 1'b1;
                w_fire = out_ready;
                if (out_ready) w_fsm_nxt = S_IDLE;
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    // Block capture, in-place lane update, output valid and block counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_blk_cnt   <= '0;
            r_mode      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_state <= in_data;
                r_idx   <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
                r_mode  <= mode;
`else
                r_mode  <= 1'b0;
`endif
            end
            if (r_fsm == S_BUSY) begin
                r_state <= w_next;
                r_idx   <= r_idx + STEP;
            end
            if (w_last) r_out_valid <= 1'b1;
            if (w_fire) begin
                r_out_valid <= 1'b0;
                r_blk_cnt   <= r_blk_cnt + 16'd1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid ? r_state : '0;
    assign blk_count = r_blk_cnt;

`ifndef INV_SUB_BYTES_FWD_EN
    logic w_unused;
    assign w_unused = r_mode;
`endif

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Bench for inv_sub_bytes_seq: LANES 1, 4 and 16 instances against
// an S-box table model built from the GF(2^8) field definition.
module tb_inv_sub_bytes_seq;

    logic         clk;
    logic         rst_n;
    logic         iv  [3];
    logic [127:0] id  [3];
    logic         orr [3];
    logic         ir  [3];
    logic         ov  [3];
    logic [127:0] od  [3];
    logic         bz  [3];
    logic [15:0]  bc  [3];
`ifdef INV_SUB_BYTES_FWD_EN
    logic         md  [3];
`endif

    int checks;
    int failures;
    logic [15:0] exp_bc [3];
    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_sub_bytes_seq #(
            .LANES(g == 0 ? 1 : (g == 1 ? 4 : 16))
        ) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (iv[g]),
            .in_ready (ir[g]),
            .in_data  (id[g]),
`ifdef INV_SUB_BYTES_FWD_EN
            .mode     (md[g]),
`endif
            .out_valid(ov[g]),
            .out_ready(orr[g]),
            .out_data (od[g]),
            .busy     (bz[g]),
            .blk_count(bc[g])
        );
    end

    function automatic int lanes_of(input int d);
        return d == 0 ? 1 : (d == 1 ? 4 : 16);
    endfunction

    function automatic int gm(input int a, input int b);
        int p;
        p = 0;
        for (int i = 0; i < 8; i++)
            if (((b >> i) & 1) == 1) p = p ^ (a << i);
        for (int bit_i = 14; bit_i >= 8; bit_i--)
            if (((p >> bit_i) & 1) == 1) p = p ^ (32'h11B << (bit_i - 8));
        return p;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] x,
                                           input logic fwd);
        logic [127:0] y;
        logic [7:0] b;
        y = '0;
        for (int k = 0; k < 16; k++) begin
            b = x[127-8*k -: 8];
            y[127-8*k -: 8] = fwd ? sb[b] : isb[b];
        end
        return y;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input int d, input logic [127:0] data);
        int n;
        n = 0;
        while (!ir[d] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) chk("send_timeout", 128'(ir[d]), 128'd1);
        iv[d] = 1'b1;
        id[d] = data;
        @(posedge clk);
        #1;
        iv[d] = 1'b0;
        id[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic recv(input int d, input logic [127:0] exp,
                        input int lat, input int hold);
        int n;
        n = 0;
        while (!ov[d] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (lat >= 0) chk("latency", 128'(n), 128'(lat));
        chk("out_data", od[d], exp);
        chk("busy_done", 128'(bz[d]), 128'd1);
        for (int h = 0; h < hold; h++) begin
            if (h == 5) begin
                iv[d] = 1'b1;
                id[d] = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            @(posedge clk);
            #1;
            iv[d] = 1'b0;
            chk("hold_data", od[d], exp);
            chk("hold_valid", 128'(ov[d]), 128'd1);
            chk("hold_ready", 128'(ir[d]), 128'd0);
        end
        orr[d] = 1'b1;
        @(posedge clk);
        #1;
        orr[d] = 1'b0;
        exp_bc[d] = exp_bc[d] + 16'd1;
        chk("valid_drop", 128'(ov[d]), 128'd0);
        chk("blk_count", 128'(bc[d]), 128'(exp_bc[d]));
        chk("idle_ready", 128'(ir[d]), 128'd1);
        chk("idle_busy", 128'(bz[d]), 128'd0);
    endtask

    task automatic chk_reset(input int d);
        chk("rst_in_ready", 128'(ir[d]), 128'd1);
        chk("rst_out_valid", 128'(ov[d]), 128'd0);
        chk("rst_out_data", od[d], 128'd0);
        chk("rst_busy", 128'(bz[d]), 128'd0);
        chk("rst_blk_count", 128'(bc[d]), 128'd0);
    endtask

    initial begin
        logic [127:0] data;
        logic [127:0] vec;
        logic [127:0] vexp;
        int inv;
        logic [7:0] s;
        logic [7:0] iv8;
        checks   = 0;
        failures = 0;

        for (int x = 0; x < 256; x++) begin
            inv = 0;
            for (int y = 1; y < 256; y++)
                if (gm(x, y) == 1) inv = y;
            iv8 = 8'(inv);
            for (int i = 0; i < 8; i++)
                s[i] = iv8[i] ^ iv8[(i+4)%8] ^ iv8[(i+5)%8] ^
                       iv8[(i+6)%8] ^ iv8[(i+7)%8] ^ ((8'h63 >> i) & 8'h01) != 0;
            sb[x]  = s;
            isb[s] = 8'(x);
        end

        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            iv[d]     = 1'b0;
            id[d]     = '0;
            orr[d]    = 1'b0;
            exp_bc[d] = '0;
`ifdef INV_SUB_BYTES_FWD_EN
            md[d]     = 1'b0;
`endif
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk_reset(d);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        orr[0] = 1'b1;
        send(0, {16{8'h63}});
        recv(0, 128'd0, 16, 0);

        vec  = 128'h000102030405060708090A0B0C0D0E0F;
        vexp = 128'h52096AD53036A538BF40A39E81F3D7FB;
        for (int d = 0; d < 3; d++) begin
            send(d, vec);
            recv(d, vexp, 16 / lanes_of(d), 0);
        end

        for (int i = 0; i < 6; i++) begin
            for (int d = 0; d < 3; d++) begin
                data = {$urandom(), $urandom(), $urandom(), $urandom()};
                send(d, data);
                recv(d, model(data, 1'b0), 16 / lanes_of(d),
                     int'($urandom_range(0, 3)));
            end
        end

        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(0, data);
        recv(0, model(data, 1'b0), 16, 20);
        repeat (3) @(posedge clk);
        #1;
        chk("no_capture_valid", 128'(ov[0]), 128'd0);
        chk("no_capture_busy", 128'(bz[0]), 128'd0);

        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(0, data);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            exp_bc[d] = '0;
            chk_reset(d);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_valid", 128'(ov[0]), 128'd0);
        chk("post_rst_count", 128'(bc[0]), 128'd0);
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(0, data);
        recv(0, model(data, 1'b0), 16, 0);

        force g_dut[0].u_dut.r_blk_cnt = 16'hFFFF;
        @(negedge clk);
        release g_dut[0].u_dut.r_blk_cnt;
        @(posedge clk);
        #1;
        chk("preload_count", 128'(bc[0]), 128'hFFFF);
        exp_bc[0] = 16'hFFFF;
        data = {$urandom(), $urandom(), $urandom(), $urandom()};
        send(0, data);
        recv(0, model(data, 1'b0), 16, 0);
        chk("wrap_count", 128'(bc[0]), 128'd0);

`ifdef INV_SUB_BYTES_FWD_EN
        md[0] = 1'b1;
        send(0, 128'd0);
        md[0] = 1'b0;
        recv(0, {16{8'h63}}, 16, 0);
        send(0, {16{8'h63}});
        recv(0, 128'd0, 16, 0);
        for (int d = 0; d < 3; d++) begin
            data = {$urandom(), $urandom(), $urandom(), $urandom()};
            md[d] = 1'b1;
            send(d, data);
            md[d] = 1'b0;
            recv(d, model(data, 1'b1), 16 / lanes_of(d), 2);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
